// File: rtl/bus_rr_arbiter.sv
// Three-master round-robin bus arbiter with bounded hold time and registered one-hot grants.
// Optional owner lock inputs (suppress hold-timeout preemption) are enabled by defining ARB_LOCK_EN.
module bus_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m2_req,
`ifdef ARB_LOCK_EN
  input  logic       m0_lock,
  input  logic       m1_lock,
  input  logic       m2_lock,
`endif
  output logic       m0_grant,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic [1:0] m_sel,
  output logic       bus_busy,
  output logic       preempt,
  output logic [1:0] o_dbg_state
);

  // Handshake: mk_req is level-held for the whole transfer; mk_grant owns the bus
  // from the edge after the request is sampled until the edge where mk_req is seen
  // low (release) or the hold timeout hands the bus to a waiting master.
  typedef enum logic [1:0] {
    OWN0 = 2'd0,
    OWN1 = 2'd1,
    OWN2 = 2'd2,
    IDLE = 2'd3
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [1:0]        r_last_owner;
  logic [1:0]        w_next_last;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_next_hold;
  logic [HOLD_W-1:0] w_hold_inc;
  logic              r_preempt;
  logic              w_next_preempt;
  logic [2:0]        r_grant;
  logic [2:0]        w_next_grant;
  logic [1:0]        r_m_sel;
  logic              r_busy;

  logic [2:0]        w_req;
  logic [2:0]        w_lock;
  logic [2:0]        w_others;
  logic [1:0]        w_own_idx;
  logic [1:0]        w_pick_idle;
  logic [1:0]        w_pick_next;
  logic              w_timeout;

  // Returns the first requester after base in rotation (base itself last), 3 if none.
  function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [2:0] req);
    logic [1:0] c1;
    logic [1:0] c2;
    logic [1:0] pick;
    c1   = (base == 2'd2) ? 2'd0 : base + 2'd1;
    c2   = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    pick = 2'd3;
    if (req[c1])        pick = c1;
    else if (req[c2])   pick = c2;
    else if (req[base]) pick = base;
    return pick;
  endfunction

  assign w_req = {m2_req, m1_req, m0_req};

`ifdef ARB_LOCK_EN
  assign w_lock = {m2_lock, m1_lock, m0_lock};
`else
  assign w_lock = 3'b000;
`endif

  assign w_own_idx   = r_state;
  assign w_others    = w_req & ~(3'b001 << w_own_idx);
  assign w_pick_idle = rr_pick(r_last_owner, w_req);
  assign w_pick_next = rr_pick(w_own_idx, w_others);

  // Counter saturates at the timeout value; with MAX_HOLD=0 it never moves.
  assign w_hold_inc = ((MAX_HOLD == 0) || (r_hold_cnt == HOLD_LAST)) ?
                      r_hold_cnt : r_hold_cnt + 1'b1;
  assign w_timeout  = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST) && !w_lock[w_own_idx];

  always_comb begin
    w_next_state   = r_state;
    w_next_last    = r_last_owner;
    w_next_hold    = r_hold_cnt;
    w_next_preempt = 1'b0;
    if (r_state == IDLE) begin
      if (|w_req) begin
        w_next_state = state_t'(w_pick_idle);
        w_next_last  = w_pick_idle;
        w_next_hold  = '0;
      end
    end else if (!w_req[w_own_idx]) begin
      if (|w_others) begin
        w_next_state = state_t'(w_pick_next);
        w_next_last  = w_pick_next;
        w_next_hold  = '0;
      end else begin
        w_next_state = IDLE;
        w_next_hold  = '0;
      end
    end else if (!(|w_others)) begin
      w_next_hold = w_hold_inc;
    end else if (w_timeout) begin
      w_next_state   = state_t'(w_pick_next);
      w_next_last    = w_pick_next;
      w_next_hold    = '0;
      w_next_preempt = 1'b1;
    end else begin
      w_next_hold = w_hold_inc;
    end
  end

  always_comb begin
    w_next_grant = 3'b000;
    case (w_next_state)
      OWN0:    w_next_grant = 3'b001;
      OWN1:    w_next_grant = 3'b010;
      OWN2:    w_next_grant = 3'b100;
      default: w_next_grant = 3'b000;
    endcase
  end

  // Outputs are flopped decodes of the next state so they always match r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_owner <= 2'd2;
      r_hold_cnt   <= '0;
      r_preempt    <= 1'b0;
      r_grant      <= 3'b000;
      r_m_sel      <= 2'd3;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_last_owner <= w_next_last;
      r_hold_cnt   <= w_next_hold;
      r_preempt    <= w_next_preempt;
      r_grant      <= w_next_grant;
      r_m_sel      <= w_next_state;
      r_busy       <= (w_next_state != IDLE);
    end
  end

  assign m0_grant    = r_grant[0];
  assign m1_grant    = r_grant[1];
  assign m2_grant    = r_grant[2];
  assign m_sel       = r_m_sel;
  assign bus_busy    = r_busy;
  assign preempt     = r_preempt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: directed steps plus random requests against a
// behavioural round-robin model; define ARB_LOCK_EN to also exercise the lock inputs.
module tb_bus_rr_arbiter;

  localparam int TB_MAX_HOLD = 4;
  localparam int TB_HOLD_W   = 4;

  logic       clk;
  logic       reset_n;
  logic [2:0] m_req;
  logic [2:0] m_lock;
  logic       m0_grant;
  logic       m1_grant;
  logic       m2_grant;
  logic [1:0] m_sel;
  logic       bus_busy;
  logic       preempt;
  logic [1:0] dbg_state;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: owner -1 means nobody owns the bus.
  int mdl_owner;
  int mdl_last;
  int mdl_hold;
  bit mdl_pre;

  logic [6:0] exp_q[$];

  bus_rr_arbiter #(
    .MAX_HOLD(TB_MAX_HOLD),
    .HOLD_W  (TB_HOLD_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m0_req     (m_req[0]),
    .m1_req     (m_req[1]),
    .m2_req     (m_req[2]),
`ifdef ARB_LOCK_EN
    .m0_lock    (m_lock[0]),
    .m1_lock    (m_lock[1]),
    .m2_lock    (m_lock[2]),
`endif
    .m0_grant   (m0_grant),
    .m1_grant   (m1_grant),
    .m2_grant   (m2_grant),
    .m_sel      (m_sel),
    .bus_busy   (bus_busy),
    .preempt    (preempt),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model
  function automatic int next_in_rot(input int base, input logic [2:0] req);
    for (int d = 1; d <= 3; d++) begin
      int c;
      c = (base + d) % 3;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mdl_owner = -1;
    mdl_last  = 2;
    mdl_hold  = 0;
    mdl_pre   = 1'b0;
  endtask

  task automatic model_give(input int n);
    mdl_owner = n;
    mdl_last  = n;
    mdl_hold  = 0;
  endtask

  task automatic model_edge(input logic [2:0] req, input logic [2:0] lock);
    int         nxt;
    logic [2:0] others;
    int         hold_max;
    hold_max = (TB_MAX_HOLD == 0) ? 0 : TB_MAX_HOLD - 1;
    mdl_pre  = 1'b0;
    if (mdl_owner < 0) begin
      nxt = next_in_rot(mdl_last, req);
      if (nxt >= 0) model_give(nxt);
    end else begin
      others            = req;
      others[mdl_owner] = 1'b0;
      if (!req[mdl_owner]) begin
        nxt = next_in_rot(mdl_owner, others);
        if (nxt >= 0) model_give(nxt);
        else begin
          mdl_owner = -1;
          mdl_hold  = 0;
        end
      end else if (others == 3'b000 || lock[mdl_owner] || TB_MAX_HOLD == 0 ||
                   mdl_hold < hold_max) begin
        mdl_hold = (mdl_hold + 1 > hold_max) ? hold_max : mdl_hold + 1;
      end else begin
        model_give(next_in_rot(mdl_owner, others));
        mdl_pre = 1'b1;
      end
    end
  endtask

  function automatic logic [6:0] model_vec();
    logic [2:0] g;
    logic [1:0] s;
    g = (mdl_owner < 0) ? 3'b000 : 3'(1 << mdl_owner);
    s = (mdl_owner < 0) ? 2'd3 : 2'(mdl_owner);
    return {g, s, (mdl_owner >= 0), mdl_pre};
  endfunction

  // Driver: present inputs, take one active edge, then score the outputs 1 ns later.
  task automatic step(input logic [2:0] req, input logic [2:0] lock);
    logic [6:0] obs;
    logic [6:0] exp;
    m_req  = req;
    m_lock = lock;
    @(posedge clk);
    model_edge(req, lock);
    exp_q.push_back(model_vec());
    #1;
    obs = {m2_grant, m1_grant, m0_grant, m_sel, bus_busy, preempt};
    if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      exp = exp_q.pop_front();
      check($sformatf("cycle@%0t", $time), 32'(obs), 32'(exp));
    end
    check("onehot", 32'($countones({m2_grant, m1_grant, m0_grant}) <= 1), 32'd1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    m_req   = 3'b000;
    m_lock  = 3'b000;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int         cnt;
    int         busy_cnt;
    int         pre_cnt;
    bit         seen_pre;
    int         age;
    int         prev_owner;
    int         order_q[$];
    logic [2:0] r;
    logic [2:0] lk;

    reset_n = 1'b0;
    m_req   = 3'b000;
    m_lock  = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grants", {m2_grant, m1_grant, m0_grant}, 3'b000);
    check("rst_m_sel", m_sel, 2'd3);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_preempt", preempt, 1'b0);
    reset_n = 1'b1;

    // Single master request / release with one-cycle latency.
    step(3'b000, 3'b000);
    m_req = 3'b001;
    #1;
    check("no_comb_path", m0_grant, 1'b0);
    step(3'b001, 3'b000);
    check("t1_grant", m0_grant, 1'b1);
    check("t1_m_sel", m_sel, 2'd0);
    repeat (3) step(3'b001, 3'b000);
    step(3'b000, 3'b000);
    check("t1_release_m_sel", m_sel, 2'd3);
    check("t1_release_busy", bus_busy, 1'b0);

    // All three request; each drops its request 3 cycles after being granted.
    apply_reset();
    r          = 3'b111;
    age        = 0;
    prev_owner = -1;
    busy_cnt   = 0;
    repeat (11) begin
      step(r, 3'b000);
      if (bus_busy) busy_cnt++;
      if (m_sel != 2'd3 && (order_q.size() == 0 || order_q[$] != int'(m_sel)))
        order_q.push_back(int'(m_sel));
      if (mdl_owner >= 0) begin
        age = (mdl_owner == prev_owner) ? age + 1 : 1;
        if (age == 3) r[mdl_owner] = 1'b0;
      end
      prev_owner = mdl_owner;
    end
    check("rr_order_len", order_q.size(), 3);
    if (order_q.size() == 3) begin
      check("rr_order_0", order_q[0], 0);
      check("rr_order_1", order_q[1], 1);
      check("rr_order_2", order_q[2], 2);
    end
    check("rr_busy_cycles", busy_cnt, 9);

    // Hold timeout: m0 held, m1 joins one cycle after the grant.
    apply_reset();
    step(3'b001, 3'b000);
    cnt      = m0_grant ? 1 : 0;
    seen_pre = 1'b0;
    repeat (4) begin
      step(3'b011, 3'b000);
      if (m0_grant) cnt++;
      if (m1_grant && preempt) seen_pre = 1'b1;
    end
    check("hold_m0_cycles", cnt, TB_MAX_HOLD);
    check("hold_preempt_with_m1", seen_pre, 1'b1);
    step(3'b011, 3'b000);
    check("preempt_one_cycle", preempt, 1'b0);
    step(3'b001, 3'b000);
    check("m0_regrant", m0_grant, 1'b1);

    // m0 alone for 20 cycles: never preempted.
    cnt     = 0;
    pre_cnt = 0;
    repeat (20) begin
      step(3'b001, 3'b000);
      if (m0_grant) cnt++;
      if (preempt) pre_cnt++;
    end
    check("alone_grant_cycles", cnt, 20);
    check("alone_preempts", pre_cnt, 0);

    // Asynchronous reset while m1 owns the bus.
    apply_reset();
    step(3'b010, 3'b000);
    step(3'b010, 3'b000);
    check("m1_owner", m1_grant, 1'b1);
    reset_n = 1'b0;
    model_reset();
    #2;
    check("async_rst_m1", m1_grant, 1'b0);
    check("async_rst_m_sel", m_sel, 2'd3);
    m_req = 3'b111;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(3'b111, 3'b000);
    check("post_rst_first", {m2_grant, m1_grant, m0_grant}, 3'b001);

`ifdef ARB_LOCK_EN
    // Lock suppresses the timeout; dropping it hands over at the next edge.
    apply_reset();
    step(3'b001, 3'b000);
    cnt     = 0;
    pre_cnt = 0;
    repeat (10) begin
      step(3'b011, 3'b001);
      if (m0_grant) cnt++;
      if (preempt) pre_cnt++;
    end
    check("lock_m0_cycles", cnt, 10);
    check("lock_preempts", pre_cnt, 0);
    step(3'b011, 3'b000);
    check("unlock_m1", m1_grant, 1'b1);
    check("unlock_preempt", preempt, 1'b1);
`endif

    // Random level-held requests.
    apply_reset();
    r = 3'b000;
    repeat (300) begin
      for (int k = 0; k < 3; k++) begin
        if (r[k]) begin
          if ($urandom_range(0, 3) == 0) r[k] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) r[k] = 1'b1;
      end
`ifdef ARB_LOCK_EN
      lk = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
`else
      lk = 3'b000;
`endif
      step(r, lk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
